fetch_instruction: RTL

Instruction-fetch stage that sources the valid/instruction/PC stream consumed by the decode stage. It owns the program counter, issues reads to a 1-cycle-latency instruction memory and buffers returned words in a 2-entry skid buffer, so decode back-pressure never loses an in-flight word. It is flushed and redirected by the branch signal shared with decode.

---
 rtl/fetch_instruction_pkg.sv | 19 +
 rtl/fetch_instruction_if.sv | 29 ++
 rtl/fetch_buffer.sv | 85 ++++++++
 rtl/fetch_instruction.sv | 72 +++++++
 4 files changed

// File: rtl/fetch_instruction_pkg.sv
// Shared widths, defaults and skid-buffer helpers for the instruction-fetch stage.
package fetch_instruction_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int PC_STEP_DEF = 4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF = '0;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W = 2;

  typedef logic [CNT_W-1:0] fifo_count_t;

  // Room for one more word once buffered and in-flight words are accounted for.
  function automatic logic has_room(input fifo_count_t count, input logic inflight);
    return ({1'b0, count} + {{CNT_W{1'b0}}, inflight}) < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/fetch_instruction_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-facing stream.
interface fetch_instruction_if
  import fetch_instruction_pkg::*;
#(
  parameter int WORD = WORD_W,
  parameter int ADDR = ADDR_W
) ();

  logic            imem_req_o;
  logic [ADDR-1:0] imem_addr_o;
  logic [WORD-1:0] imem_data_i;
  logic            v_o;
  logic [WORD-1:0] inst_o;
  logic [ADDR-1:0] pc_o;
  logic            stall_i;
  logic            branch_i;
  logic [ADDR-1:0] branch_pc_i;

  modport master (
    output imem_req_o, imem_addr_o, v_o, inst_o, pc_o,
    input  imem_data_i, stall_i, branch_i, branch_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, v_o, inst_o, pc_o,
    output imem_data_i, stall_i, branch_i, branch_pc_i
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry skid FIFO of {inst, pc}; head is presented combinationally from storage.
module fetch_buffer
  import fetch_instruction_pkg::*;
#(
  parameter int WORD = WORD_W,
  parameter int ADDR = ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write,
  input  logic [WORD-1:0] write_inst,
  input  logic [ADDR-1:0] write_pc,
  input  logic            pop,
  input  logic            flush,
  output fifo_count_t     count,
  output logic [WORD-1:0] head_inst,
  output logic [ADDR-1:0] head_pc
);

  logic        wr_ptr_reg, wr_ptr_next;
  logic        rd_ptr_reg, rd_ptr_next;
  fifo_count_t count_reg, count_next;
  logic        pop_ok, write_en;

  logic [WORD-1:0] inst_q [FIFO_DEPTH];
  logic [ADDR-1:0] pc_q   [FIFO_DEPTH];

  // A full buffer still accepts a write when the head leaves on the same edge.
  assign pop_ok   = pop & (count_reg != '0);
  assign write_en = write & ~flush & ((count_reg != fifo_count_t'(FIFO_DEPTH)) | pop_ok);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = 1'b0;
      rd_ptr_next = 1'b0;
      count_next  = '0;
    end else begin
      if (write_en) wr_ptr_next = ~wr_ptr_reg;
      if (pop_ok)   rd_ptr_next = ~rd_ptr_reg;
      case ({write_en, pop_ok})
        2'b10:   count_next = count_reg + fifo_count_t'(1);
        2'b01:   count_next = count_reg - fifo_count_t'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [WORD-1:0] inst_reg;
    logic [ADDR-1:0] pc_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        inst_reg <= '0;
        pc_reg   <= '0;
      end else if (write_en && (wr_ptr_reg == 1'(gi))) begin
        inst_reg <= write_inst;
        pc_reg   <= write_pc;
      end
    end

    assign inst_q[gi] = inst_reg;
    assign pc_q[gi]   = pc_reg;
  end

  assign count     = count_reg;
  assign head_inst = inst_q[rd_ptr_reg];
  assign head_pc   = pc_q[rd_ptr_reg];

endmodule

// File: rtl/fetch_instruction.sv
// Instruction-fetch stage: owns the PC, issues 1-cycle-latency memory reads and
// feeds decode through a 2-entry skid buffer; branch flushes and redirects.
module fetch_instruction
  import fetch_instruction_pkg::*;
#(
  parameter int            WORD     = WORD_W,
  parameter int            ADDR     = ADDR_W,
  parameter int            PC_STEP  = PC_STEP_DEF,
  parameter logic [ADDR-1:0] RESET_PC = ADDR'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  fetch_instruction_if.master bus
);

  logic [ADDR-1:0] pc_reg;
  logic            inflight_v_reg;
  logic [ADDR-1:0] inflight_pc_reg;

  logic            branch;
  logic            pop;
  logic            req;
  logic [ADDR-1:0] addr;
  fifo_count_t     count;
  logic [WORD-1:0] head_inst;
  logic [ADDR-1:0] head_pc;

  assign branch = bus.branch_i;
  assign pop    = bus.v_o & ~bus.stall_i;

  // Reset gating keeps the memory idle while reset is held low.
  assign req  = reset & (branch | has_room(count, inflight_v_reg) | pop);
  assign addr = branch ? bus.branch_pc_i : pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg          <= RESET_PC;
      inflight_v_reg  <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      inflight_v_reg <= req;
      if (req) begin
        pc_reg          <= addr + ADDR'(PC_STEP);
        inflight_pc_reg <= addr;
      end
    end
  end

  // A branch discards the response landing this cycle and ignores decode's pop.
  fetch_buffer #(
    .WORD (WORD),
    .ADDR (ADDR)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .write      (inflight_v_reg & ~branch),
    .write_inst (bus.imem_data_i),
    .write_pc   (inflight_pc_reg),
    .pop        (pop & ~branch),
    .flush      (branch),
    .count      (count),
    .head_inst  (head_inst),
    .head_pc    (head_pc)
  );

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = addr;
  assign bus.v_o         = (count != '0);
  assign bus.inst_o      = head_inst;
  assign bus.pc_o        = head_pc;

endmodule
